// File: rtl/ctrl_pkt_pkg.sv
// ctrl_pkt_pkg: shared constants, size helpers and FSM states for the control packet transmitter
package ctrl_pkt_pkg;
  localparam int STAGE_OFF = 0;
  localparam int IDX_OFF = 8;
  localparam int SEQ_OFF = 16;
  localparam int NBEAT_OFF = 24;
  localparam logic [2:0] MOD_KEY_EXT = 3'd0;
  localparam logic [2:0] MOD_LOOKUP = 3'd1;
  localparam logic [2:0] MOD_ACTION = 3'd2;
  typedef enum logic [1:0] {IDLE, HDR, DATA, GAP} state_t;
  function automatic int ndata(input int pw, input int dw);
    return (pw + dw - 1) / dw;
  endfunction
  function automatic int last_bytes(input int pw, input int dw);
    return (pw - (ndata(pw, dw) - 1) * dw + 7) / 8;
  endfunction
  function automatic int pkt_bytes(input int pw, input int dw);
    return 64 * ndata(pw, dw) + last_bytes(pw, dw);
  endfunction
endpackage

// File: rtl/ctrl_pkt_tx_beat_mux.sv
// ctrl_pkt_beat_mux: selects one zero-padded payload slice and its byte enables for a data beat
//   payload : latched request payload (PW bits)
//   beat    : data beat index, 0 .. ndata-1
//   tdata   : payload bits [beat*DW +: DW], zero above PW
//   tkeep   : all-ones, or the low last_bytes bits on the final beat
module ctrl_pkt_beat_mux
  import ctrl_pkt_pkg::*;
#(
  parameter int DW = 512,
  parameter int PW = 625
) (
  input  logic [PW-1:0]   payload,
  input  logic [1:0]      beat,
  output logic [DW-1:0]   tdata,
  output logic [DW/8-1:0] tkeep
);
  localparam logic [1:0] LAST_BEAT = 2'(ndata(PW, DW) - 1);
  localparam logic [DW/8-1:0] ALL_KEEP = {(DW/8){1'b1}};
  localparam logic [DW/8-1:0] LAST_KEEP = ALL_KEEP >> (DW / 8 - last_bytes(PW, DW));
  logic [4*DW-1:0] padded;
  assign padded = (4 * DW)'(payload);
  assign tdata = padded[int'(beat) * DW +: DW];
  assign tkeep = beat == LAST_BEAT ? LAST_KEEP : ALL_KEEP;
endmodule

// File: rtl/ctrl_pkt_tx.sv
// ctrl_pkt_tx: turns table write requests into paced multi-beat AXIS control packets
//   axis_clk, reset        : clock, synchronous active-high reset
//   req_valid/req_ready    : request handshake, ready only while idle
//   req_stage_id/_module_id/_index/_data : request fields, captured on acceptance
//   c_m_axis_*             : registered control packet stream (no back-pressure)
//   pkt_cnt, beat_cnt      : packet/beat statistics, present only with CTRL_TX_STATS_EN
module ctrl_pkt_tx
  import ctrl_pkt_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int PAYLOAD_W = 625,
  parameter int IPG_CYCLES = 4,
  parameter logic [7:0] SRC_PORT = 8'h01
) (
  input  logic                              axis_clk,
  input  logic                              reset,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [4:0]                        req_stage_id,
  input  logic [2:0]                        req_module_id,
  input  logic [7:0]                        req_index,
  input  logic [PAYLOAD_W-1:0]              req_data,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
  output logic                              c_m_axis_tvalid,
  output logic                              c_m_axis_tlast
`ifdef CTRL_TX_STATS_EN
  ,
  output logic [31:0]                       pkt_cnt,
  output logic [31:0]                       beat_cnt
`endif
);
  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int TW = C_S_AXIS_TUSER_WIDTH;
  localparam int NB = ndata(PAYLOAD_W, DW);
  localparam logic [1:0] LAST_BEAT = 2'(NB - 1);
  localparam logic [7:0] GAP_LAST = 8'(IPG_CYCLES - 1);
  localparam logic [15:0] PKT_LEN = 16'(pkt_bytes(PAYLOAD_W, DW));
  state_t state, state_n;
  logic [1:0] beat, beat_n;
  logic [7:0] seq, seq_n, gap, gap_n;
  logic accept;
  logic [PAYLOAD_W-1:0] h_data;
  logic [DW-1:0] hdr, mux_data;
  logic [DW/8-1:0] mux_keep;
  logic [TW-1:0] hdr_user;
  ctrl_pkt_beat_mux #(.DW(DW), .PW(PAYLOAD_W)) u_mux (
    .payload(h_data),
    .beat(beat_n),
    .tdata(mux_data),
    .tkeep(mux_keep)
  );
  always_comb begin
    accept = req_valid & req_ready;
    state_n = state;
    beat_n = beat;
    seq_n = seq;
    gap_n = gap;
    unique case (state)
      IDLE: state_n = accept ? HDR : IDLE;
      HDR: begin
        state_n = DATA;
        beat_n = '0;
      end
      DATA: begin
        if (beat == LAST_BEAT) begin
          state_n = IPG_CYCLES == 0 ? IDLE : GAP;
          seq_n = seq + 8'd1;
          gap_n = '0;
        end else begin
          beat_n = beat + 2'd1;
        end
      end
      GAP: begin
        state_n = gap == GAP_LAST ? IDLE : GAP;
        gap_n = gap + 8'd1;
      end
      default: state_n = IDLE;
    endcase
    // the header is built straight from the request inputs, since it goes out on the acceptance edge
    hdr = '0;
    hdr[STAGE_OFF +: 8] = {req_stage_id, req_module_id};
    hdr[IDX_OFF +: 8] = req_index;
    hdr[SEQ_OFF +: 8] = seq;
    hdr[NBEAT_OFF +: 8] = 8'(NB);
    hdr_user = '0;
    hdr_user[15:0] = PKT_LEN;
    hdr_user[23:16] = SRC_PORT;
  end
  always_ff @(posedge axis_clk)
    if (accept) h_data <= req_data;
  // output registers load the beat belonging to the next state
  always_ff @(posedge axis_clk) begin
    if (reset) begin
      state <= IDLE;
      beat <= '0;
      seq <= '0;
      gap <= '0;
      req_ready <= 1'b0;
      c_m_axis_tvalid <= 1'b0;
      c_m_axis_tlast <= 1'b0;
      c_m_axis_tdata <= '0;
      c_m_axis_tkeep <= '0;
      c_m_axis_tuser <= '0;
    end else begin
      state <= state_n;
      beat <= beat_n;
      seq <= seq_n;
      gap <= gap_n;
      req_ready <= state_n == IDLE;
      c_m_axis_tvalid <= state_n == HDR || state_n == DATA;
      c_m_axis_tlast <= state_n == DATA && beat_n == LAST_BEAT;
      c_m_axis_tdata <= state_n == HDR ? hdr : state_n == DATA ? mux_data : '0;
      c_m_axis_tkeep <= state_n == HDR ? '1 : state_n == DATA ? mux_keep : '0;
      c_m_axis_tuser <= state_n == HDR ? hdr_user : '0;
    end
  end
`ifdef CTRL_TX_STATS_EN
  always_ff @(posedge axis_clk) begin
    if (reset) begin
      pkt_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      pkt_cnt <= pkt_cnt + 32'(c_m_axis_tvalid & c_m_axis_tlast);
      beat_cnt <= beat_cnt + 32'(c_m_axis_tvalid);
    end
  end
`endif
endmodule

// File: tb/tb_ctrl_pkt_tx.sv
// tb_ctrl_pkt_tx: randomized self-checking bench for ctrl_pkt_tx (default build plus a 512-bit, zero-gap build)
module tb_ctrl_pkt_tx;
  localparam int DW = 512, TW = 128, KW = DW / 8, PW = 625, IPG = 4;
  localparam int ND = (PW + DW - 1) / DW;
  localparam int PW2 = 512;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_valid2 = 0;
  logic [4:0] req_stage_id = 0;
  logic [2:0] req_module_id = 0;
  logic [7:0] req_index = 0;
  logic [PW-1:0] req_data = '0;
  logic [PW2-1:0] req_data2 = '0;
  logic req_ready, req_ready2;
  logic [DW-1:0] c_m_axis_tdata, d2_tdata;
  logic [TW-1:0] c_m_axis_tuser, d2_tuser;
  logic [KW-1:0] c_m_axis_tkeep, d2_tkeep;
  logic c_m_axis_tvalid, c_m_axis_tlast, d2_tvalid, d2_tlast;
`ifdef CTRL_TX_STATS_EN
  logic [31:0] pkt_cnt, beat_cnt, pkt_cnt2, beat_cnt2;
`endif
  int errors = 0, checks = 0, cyc = 0;
  logic [7:0] exp_seq = 0;
  logic [DW-1:0] cap_d [0:ND];
  logic [KW-1:0] cap_k [0:ND];
  logic [TW-1:0] cap_u [0:ND];
  logic cap_v [0:ND];
  logic cap_l [0:ND];
  int rdy_low, gap_valid, hdr_cyc;

  ctrl_pkt_tx dut (
    .axis_clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_stage_id(req_stage_id), .req_module_id(req_module_id), .req_index(req_index),
    .req_data(req_data), .c_m_axis_tdata(c_m_axis_tdata), .c_m_axis_tuser(c_m_axis_tuser),
    .c_m_axis_tkeep(c_m_axis_tkeep), .c_m_axis_tvalid(c_m_axis_tvalid), .c_m_axis_tlast(c_m_axis_tlast)
`ifdef CTRL_TX_STATS_EN
    , .pkt_cnt(pkt_cnt), .beat_cnt(beat_cnt)
`endif
  );
  ctrl_pkt_tx #(.PAYLOAD_W(PW2), .IPG_CYCLES(0)) dut2 (
    .axis_clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_stage_id(req_stage_id), .req_module_id(req_module_id), .req_index(req_index),
    .req_data(req_data2), .c_m_axis_tdata(d2_tdata), .c_m_axis_tuser(d2_tuser),
    .c_m_axis_tkeep(d2_tkeep), .c_m_axis_tvalid(d2_tvalid), .c_m_axis_tlast(d2_tlast)
`ifdef CTRL_TX_STATS_EN
    , .pkt_cnt(pkt_cnt2), .beat_cnt(beat_cnt2)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] exp_hdr(input logic [4:0] st, input logic [2:0] md, input logic [7:0] ix, input logic [7:0] sq, input int nd);
    logic [DW-1:0] h = '0;
    h[31:0] = {8'(nd), sq, ix, st, md};
    return h;
  endfunction
  function automatic logic [DW-1:0] exp_data(input logic [PW-1:0] d, input int k);
    logic [DW-1:0] r = '0;
    for (int i = 0; i < DW; i++) if (k * DW + i < PW) r[i] = d[k * DW + i];
    return r;
  endfunction
  // a byte is enabled exactly when it holds at least one payload bit
  function automatic logic [KW-1:0] exp_keep(input int k);
    logic [KW-1:0] r = '0;
    for (int i = 0; i < KW; i++) r[i] = (k * DW + i * 8) < PW;
    return r;
  endfunction
  function automatic logic [PW-1:0] rand_payload();
    logic [639:0] t;
    for (int i = 0; i < 20; i++) t[i * 32 +: 32] = $urandom;
    return t[PW-1:0];
  endfunction

  // drives one request on DUT 1 and records its beats; always returns on a negedge
  task automatic xfer(input logic [4:0] st, input logic [2:0] md, input logic [7:0] ix,
                      input logic [PW-1:0] d, input bit hold, input bit scramble);
    int n = 0;
    req_stage_id = st; req_module_id = md; req_index = ix; req_data = d; req_valid = 1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      errors++; checks++;
      $display("FAIL accept_timeout req_ready=%0b required 1", req_ready);
      req_valid = 0;
      return;
    end
    rdy_low = 0; gap_valid = 0;
    for (int b = 0; b <= ND; b++) begin
      @(negedge clk);
      if (b == 0) begin
        hdr_cyc = cyc;
        req_valid = hold;
        if (scramble) req_data = ~d;
      end
      cap_d[b] = c_m_axis_tdata; cap_k[b] = c_m_axis_tkeep; cap_u[b] = c_m_axis_tuser;
      cap_v[b] = c_m_axis_tvalid; cap_l[b] = c_m_axis_tlast;
      if (!req_ready) rdy_low++;
    end
    for (int g = 0; g < 64; g++) begin
      @(negedge clk);
      if (req_ready) break;
      rdy_low++;
      gap_valid += int'(c_m_axis_tvalid);
    end
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b0 || req_ready2 !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b/%b required 0/0", req_ready, req_ready2); end
    checks++; if ({c_m_axis_tvalid, c_m_axis_tlast, c_m_axis_tdata, c_m_axis_tkeep, c_m_axis_tuser} !== '0) begin errors++; $display("FAIL reset_outputs tvalid=%b tlast=%b required all zero", c_m_axis_tvalid, c_m_axis_tlast); end
    reset = 0;
    exp_seq = 0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b required 1", req_ready); end
  endtask

  task automatic test_single;
    logic [639:0] t;
    logic [PW-1:0] d;
    for (int i = 0; i < 80; i++) t[i * 8 +: 8] = 8'(i);
    d = t[PW-1:0];
    xfer(5'd2, 3'd2, 8'h05, d, 0, 0);
    checks++; if (cap_d[0][7:0] !== 8'h12) begin errors++; $display("FAIL single_hdr_id got=%h required 12", cap_d[0][7:0]); end
    checks++; if (cap_d[0][15:8] !== 8'h05) begin errors++; $display("FAIL single_hdr_idx got=%h required 05", cap_d[0][15:8]); end
    checks++; if (cap_d[0][23:16] !== 8'h00) begin errors++; $display("FAIL single_hdr_seq got=%h required 00", cap_d[0][23:16]); end
    checks++; if (cap_d[0][31:24] !== 8'd2) begin errors++; $display("FAIL single_hdr_nbeat got=%0d required 2", cap_d[0][31:24]); end
    checks++; if (cap_d[0][DW-1:32] !== '0) begin errors++; $display("FAIL single_hdr_pad got nonzero upper bits required 0"); end
    checks++; if (cap_u[0] !== TW'({8'h01, 16'd143})) begin errors++; $display("FAIL single_tuser got=%h required 01008f", cap_u[0][23:0]); end
    checks++; if (cap_v[0] !== 1'b1 || cap_l[0] !== 1'b0 || cap_k[0] !== '1) begin errors++; $display("FAIL single_hdr_ctl valid=%b last=%b keep=%h required 1 0 all-ones", cap_v[0], cap_l[0], cap_k[0]); end
    checks++; if (cap_k[1] !== {KW{1'b1}} || cap_l[1] !== 1'b0) begin errors++; $display("FAIL single_beat1_ctl keep=%h last=%b required all-ones 0", cap_k[1], cap_l[1]); end
    checks++; if (cap_k[2] !== 64'h7FFF || cap_l[2] !== 1'b1) begin errors++; $display("FAIL single_beat2_ctl keep=%h last=%b required 7fff 1", cap_k[2], cap_l[2]); end
    for (int k = 1; k <= ND; k++) begin
      checks++; if (cap_d[k] !== exp_data(d, k - 1) || cap_u[k] !== '0 || cap_v[k] !== 1'b1) begin errors++; $display("FAIL single_data beat=%0d got=%h required=%h", k, cap_d[k][63:0], exp_data(d, k - 1)); end
    end
    checks++; if (rdy_low !== 7) begin errors++; $display("FAIL single_ready_low got=%0d required 7", rdy_low); end
    checks++; if (gap_valid !== 0) begin errors++; $display("FAIL single_gap_valid got=%0d required 0", gap_valid); end
  endtask

  task automatic test_back_to_back;
    int prev = 0;
    logic [4:0] st; logic [2:0] md; logic [7:0] ix, sq; logic [PW-1:0] d;
    for (int p = 0; p < 3; p++) begin
      st = 5'($urandom); md = 3'($urandom); ix = 8'($urandom); d = rand_payload(); sq = exp_seq;
      xfer(st, md, ix, d, p < 2, 0);
      checks++; if (cap_d[0] !== exp_hdr(st, md, ix, sq, ND)) begin errors++; $display("FAIL b2b_hdr p=%0d got=%h required=%h", p, cap_d[0][31:0], exp_hdr(st, md, ix, sq, ND)); end
      if (p > 0) begin
        checks++; if (hdr_cyc - prev !== ND + 2 + IPG) begin errors++; $display("FAIL b2b_period p=%0d got=%0d required %0d", p, hdr_cyc - prev, ND + 2 + IPG); end
      end
      prev = hdr_cyc;
      for (int k = 1; k <= ND; k++) begin
        checks++; if (cap_v[k] !== 1'b1 || cap_d[k] !== exp_data(d, k - 1) || cap_k[k] !== exp_keep(k - 1)) begin errors++; $display("FAIL b2b_data p=%0d beat=%0d valid=%b keep=%h required keep=%h", p, k, cap_v[k], cap_k[k], exp_keep(k - 1)); end
      end
      checks++; if (gap_valid !== 0) begin errors++; $display("FAIL b2b_gap_valid p=%0d got=%0d required 0", p, gap_valid); end
    end
  endtask

  task automatic test_hold_register;
    logic [PW-1:0] d = rand_payload();
    xfer(5'd1, 3'd0, 8'hA5, d, 0, 1);
    for (int k = 1; k <= ND; k++) begin
      checks++; if (cap_d[k] !== exp_data(d, k - 1)) begin errors++; $display("FAIL hold_data beat=%0d got=%h required=%h", k, cap_d[k][63:0], exp_data(d, k - 1)); end
    end
  endtask

  task automatic test_seq_wrap;
    logic [4:0] st; logic [2:0] md; logic [7:0] ix, sq; logic [PW-1:0] d;
    for (int p = 0; p < 257; p++) begin
      st = 5'($urandom); md = 3'($urandom); ix = 8'($urandom); d = rand_payload(); sq = exp_seq;
      xfer(st, md, ix, d, 0, 0);
      checks++; if (cap_d[0] !== exp_hdr(st, md, ix, sq, ND)) begin errors++; $display("FAIL wrap_hdr p=%0d got=%h required=%h", p, cap_d[0][31:0], exp_hdr(st, md, ix, sq, ND)); end
      checks++; if (cap_d[ND] !== exp_data(d, ND - 1) || cap_l[ND] !== 1'b1) begin errors++; $display("FAIL wrap_last p=%0d last=%b", p, cap_l[ND]); end
    end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    logic [4:0] st; logic [2:0] md; logic [7:0] ix; logic [PW-1:0] d;
    req_stage_id = 5'd3; req_module_id = 3'd1; req_index = 8'h3C; req_data = rand_payload(); req_valid = 1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 0;
    checks++; if (c_m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL mid_hdr_valid got=%b required 1", c_m_axis_tvalid); end
    @(negedge clk);
    checks++; if (c_m_axis_tvalid !== 1'b1 || c_m_axis_tlast !== 1'b0) begin errors++; $display("FAIL mid_beat0 valid=%b last=%b required 1 0", c_m_axis_tvalid, c_m_axis_tlast); end
    reset = 1;
    @(negedge clk);
    checks++; if ({c_m_axis_tvalid, c_m_axis_tlast, c_m_axis_tdata, c_m_axis_tkeep, c_m_axis_tuser} !== '0 || req_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs valid=%b last=%b ready=%b required all zero", c_m_axis_tvalid, c_m_axis_tlast, req_ready); end
    reset = 0;
    exp_seq = 0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || c_m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL mid_release ready=%b valid=%b required 1 0", req_ready, c_m_axis_tvalid); end
    st = 5'($urandom); md = 3'($urandom); ix = 8'($urandom); d = rand_payload();
    xfer(st, md, ix, d, 0, 0);
    checks++; if (cap_d[0] !== exp_hdr(st, md, ix, 8'h00, ND)) begin errors++; $display("FAIL mid_next_hdr got=%h required=%h", cap_d[0][31:0], exp_hdr(st, md, ix, 8'h00, ND)); end
`ifdef CTRL_TX_STATS_EN
    checks++; if (pkt_cnt !== 32'd1 || beat_cnt !== 32'd3) begin errors++; $display("FAIL stats_default pkt=%0d beat=%0d required 1 3", pkt_cnt, beat_cnt); end
`endif
  endtask

  task automatic test_single_beat;
    int n = 0;
    logic [PW2-1:0] d;
    logic [639:0] t;
    for (int i = 0; i < 20; i++) t[i * 32 +: 32] = $urandom;
    d = t[PW2-1:0];
    req_stage_id = 5'd4; req_module_id = 3'd5; req_index = 8'hFF; req_data2 = d; req_valid2 = 1;
    while (!req_ready2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid2 = 0;
    checks++; if (d2_tvalid !== 1'b1 || d2_tdata !== exp_hdr(5'd4, 3'd5, 8'hFF, 8'h00, 1) || d2_tlast !== 1'b0) begin errors++; $display("FAIL one_hdr valid=%b got=%h required=%h", d2_tvalid, d2_tdata[31:0], exp_hdr(5'd4, 3'd5, 8'hFF, 8'h00, 1)); end
    checks++; if (d2_tuser !== TW'({8'h01, 16'd128})) begin errors++; $display("FAIL one_tuser got=%h required 010080", d2_tuser[23:0]); end
    @(negedge clk);
    checks++; if (d2_tvalid !== 1'b1 || d2_tlast !== 1'b1 || d2_tkeep !== {KW{1'b1}} || d2_tdata !== d) begin errors++; $display("FAIL one_data valid=%b last=%b keep=%h", d2_tvalid, d2_tlast, d2_tkeep); end
    @(negedge clk);
    checks++; if (req_ready2 !== 1'b1 || d2_tvalid !== 1'b0) begin errors++; $display("FAIL one_ready_after_last ready=%b valid=%b required 1 0", req_ready2, d2_tvalid); end
`ifdef CTRL_TX_STATS_EN
    checks++; if (pkt_cnt2 !== 32'd1 || beat_cnt2 !== 32'd2) begin errors++; $display("FAIL stats_one pkt=%0d beat=%0d required 1 2", pkt_cnt2, beat_cnt2); end
`endif
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_hold_register;
    test_seq_wrap;
    test_reset_mid;
    test_single_beat;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
